hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Sequential hazard controller for the 5-stage MIPS pipeline.
- Consumes the D-stage Tnew/Tuse decode: source registers, Tuse, and the destination and Tnew of the instruction leaving D.
- Keeps a per-stage scoreboard for E, M and W and counts Tnew down as instructions advance.
- Produces the D-stage stall and all forwarding mux selects, and runs the mult/div busy counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E.
- DIV_CYCLES, 10, busy cycles after a div/divu enters E.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- rs_D  in  5  D-stage rs field.
- rt_D  in  5  D-stage rt field.
- rs_use_D  in  1  D instruction reads rs.
- rt_use_D  in  1  D instruction reads rt.
- Tuse_rs  in  1  cycles until rs is needed (0 or 1).
- Tuse_rt  in  2  cycles until rt is needed (0..2).
- Tnew_E_D  in  2  Tnew the D instruction will have on entering E.
- WAddr_D  in  5  destination of the D instruction.
- RegWrite_D  in  1  D instruction writes the GPR file.
- md_start_D  in  1  D instruction is mult/multu/div/divu.
- md_div_D  in  1  with md_start_D: divide, not multiply.
- md_use_D  in  1  D instruction uses HI/LO or the md unit (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze PC and F/D; bubble D/E.
- fwd_rs_D  out  2  D operand select.
- fwd_rt_D  out  2  same encoding as fwd_rs_D.
- fwd_rs_E  out  2  E operand select.
- fwd_rt_E  out  2  same encoding as fwd_rs_E.
- fwd_rt_M  out  1  M store-data select.
- md_busy  out  1  md unit occupied.

Behaviour:
- Scoreboard entry per stage S in {E, M, W}: we, addr[4:0], tnew[1:0], rs[4:0], rt[4:0], md.
  - Reset clears every field to 0.
- Each rising clk, not stalled:
  - E <= {RegWrite_D & (WAddr_D != 0), WAddr_D, Tnew_E_D, rs_D, rt_D, md_start_D}.
- Each rising clk, stalled:
  - E <= all-zero bubble; D/F hold.
- Every cycle, regardless of stall:
  - M <= E with tnew = sat_dec(E.tnew).
  - W <= M with tnew = sat_dec(M.tnew).
  - sat_dec(0) = 0.
- match_X(r, S) = S.we & (S.addr == r) & (r != 0). Register $0 never matches, never stalls, never forwards.
- Stall (combinational from current state):
  - rs term: rs_use_D & ((match(rs_D,E) & E.tnew > Tuse_rs) | (match(rs_D,M) & M.tnew > Tuse_rs)).
  - rt term: the same form with rt_D and Tuse_rt.
  - md term: md_use_D & (md_busy | E.md).
  - stall = OR of the three terms.
- fwd_rs_D / fwd_rt_D:
  - 1 if match(E) & E.tnew == 0.
  - else 2 if match(M) & M.tnew == 0.
  - else 0 (register file).
  - E has priority over M.
  - W-to-D is covered by register-file write-through and is not selected here.
- fwd_rs_E / fwd_rt_E, using E.rs / E.rt:
  - 1 if match(M) & M.tnew == 0.
  - else 2 if match(W).
  - else 0 (E pipeline register).
- fwd_rt_M = match(M.rt, W); otherwise 0.
- A stalled source is never also forwarded from the same stage in the same cycle. Select values during a stall are don't-care, but they must be deterministic.
- md busy counter, cnt[3:0]:
  - Reset clears it to 0.
  - When E.md = 1: cnt <= (md_div of that E entry ? DIV_CYCLES : MULT_CYCLES). This requires md_div_D to be captured into E alongside md.
  - Otherwise, when cnt != 0: cnt <= cnt - 1.
  - md_busy = (cnt != 0).
  - E.md while cnt != 0 cannot occur (the D stall prevents it). If it does, the new load wins.
- Reset asserted mid-operation clears the scoreboard, cnt, stall and all selects immediately (asynchronously).

Decomposition:
- Package hazard_pkg holds:
  - forward select constants FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 2 (E-stage encoding);
  - scoreboard entry struct/typedef;
  - MULT_CYCLES and DIV_CYCLES defaults.
- One sub-module, md_busy_counter: the load/decrement counter producing md_busy.
- Scoreboard, stall and forward logic stay in hazard_scheduler.

Test Plan:
- lw $8 in D (Tnew_E=2), then addu using $8 as rs (Tuse_rs=1): stall=1 for exactly 1 cycle, then fwd_rs_E=2 (W) when addu reaches E.
- ori $9 (Tnew_E=1), then beq on $9 (Tuse=0): 1-cycle stall, then fwd_rs_D=2 (M) with stall=0.
- addu $10, then sw with rt=$10 (Tuse_rt=2): no stall; fwd_rt_E=1 when sw is in E.
- lw $11 with sw rt=$11 next: no stall; fwd_rt_M=1 when sw is in M.
- div (md_div_D=1), then mflo: stall held from div-in-E through 10 busy cycles, 11 cycles total; md_busy falls and stall drops the same cycle.
- Write to $0 (RegWrite=1, WAddr=0), then a $0 reader: stall=0, all selects 0.
- Reset pulse during an active lw stall: stall=0, all selects 0, md_busy=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, forward select encodings and md latency defaults
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_W = 2'd2;
  localparam logic [1:0] FWD_E_FROM_M = 2'd1;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md;
    logic       md_div;
  } sb_entry_t;
  function automatic logic sb_match(input logic [4:0] r, input sb_entry_t s);
    return s.we & (s.addr == r) & (r != 5'd0);
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: loads the mult/div latency when an md op enters E and counts it down
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? (div_i ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES))
                             : ((cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign busy_o = (cnt_q != 4'd0);
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: Tnew/Tuse scoreboard producing D-stage stall and all forwarding selects
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       rs_use_D,
  input  logic       rt_use_D,
  input  logic       Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [1:0] Tnew_E_D,
  input  logic [4:0] WAddr_D,
  input  logic       RegWrite_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic       md_busy
);
  sb_entry_t e_q, m_q, w_q, e_d, m_d, w_d;
  logic rs_stall, rt_stall, md_stall;
  always_comb begin
    e_d = stall ? '0 : '{we: RegWrite_D & (WAddr_D != 5'd0), addr: WAddr_D, tnew: Tnew_E_D,
                         rs: rs_D, rt: rt_D, md: md_start_D, md_div: md_div_D};
    m_d = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    w_d = m_q;
    w_d.tnew = sat_dec(m_q.tnew);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  md_busy_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk), .reset(reset), .load_i(e_q.md), .div_i(e_q.md_div), .busy_o(md_busy)
  );
  // a producer still computing (tnew > tuse) stalls; tnew == 0 in E/M can be forwarded instead
  assign rs_stall = rs_use_D & ((sb_match(rs_D, e_q) & (e_q.tnew > {1'b0, Tuse_rs}))
                              | (sb_match(rs_D, m_q) & (m_q.tnew > {1'b0, Tuse_rs})));
  assign rt_stall = rt_use_D & ((sb_match(rt_D, e_q) & (e_q.tnew > Tuse_rt))
                              | (sb_match(rt_D, m_q) & (m_q.tnew > Tuse_rt)));
  assign md_stall = md_use_D & (md_busy | e_q.md);
  assign stall = rs_stall | rt_stall | md_stall;
  assign fwd_rs_D = (sb_match(rs_D, e_q) & (e_q.tnew == 2'd0)) ? FWD_E
                  : (sb_match(rs_D, m_q) & (m_q.tnew == 2'd0)) ? FWD_M : FWD_RF;
  assign fwd_rt_D = (sb_match(rt_D, e_q) & (e_q.tnew == 2'd0)) ? FWD_E
                  : (sb_match(rt_D, m_q) & (m_q.tnew == 2'd0)) ? FWD_M : FWD_RF;
  assign fwd_rs_E = (sb_match(e_q.rs, m_q) & (m_q.tnew == 2'd0)) ? FWD_E_FROM_M
                  : sb_match(e_q.rs, w_q) ? FWD_W : FWD_RF;
  assign fwd_rt_E = (sb_match(e_q.rt, m_q) & (m_q.tnew == 2'd0)) ? FWD_E_FROM_M
                  : sb_match(e_q.rt, w_q) ? FWD_W : FWD_RF;
  assign fwd_rt_M = sb_match(m_q.rt, w_q);
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: scoreboard-driven checks of stall, forwarding selects and md busy
module tb_hazard_scheduler;
  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] rs_D, rt_D, WAddr_D;
  logic rs_use_D, rt_use_D, Tuse_rs, RegWrite_D, md_start_D, md_div_D, md_use_D;
  logic [1:0] Tuse_rt, Tnew_E_D;
  logic stall, fwd_rt_M, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  int tests = 0, fails = 0;
  logic [10:0] exp_q[$];
  typedef struct packed {
    logic [4:0] rs, rt;
    logic rsu, rtu, tur;
    logic [1:0] tut, tne;
    logic [4:0] wa;
    logic rw, mds, mdd, mdu;
  } ins_t;
  hazard_scheduler dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
    .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_E_D(Tnew_E_D), .WAddr_D(WAddr_D),
    .RegWrite_D(RegWrite_D), .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
  );
  always #5 clk = ~clk;
  function automatic ins_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                              input logic rtu, input logic tur, input logic [1:0] tut,
                              input logic [1:0] tne, input logic [4:0] wa, input logic rw,
                              input logic mds, input logic mdd, input logic mdu);
    return '{rs: rs, rt: rt, rsu: rsu, rtu: rtu, tur: tur, tut: tut, tne: tne, wa: wa,
             rw: rw, mds: mds, mdd: mdd, mdu: mdu};
  endfunction
  function automatic logic [10:0] ex(input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                                     input logic [1:0] rse, input logic [1:0] rte,
                                     input logic rtm, input logic bz);
    return {st, rsd, rtd, rse, rte, rtm, bz};
  endfunction
  function automatic logic [10:0] obs();
    return {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
  endfunction
  task automatic drive(input ins_t i);
    rs_D = i.rs; rt_D = i.rt; rs_use_D = i.rsu; rt_use_D = i.rtu; Tuse_rs = i.tur;
    Tuse_rt = i.tut; Tnew_E_D = i.tne; WAddr_D = i.wa; RegWrite_D = i.rw;
    md_start_D = i.mds; md_div_D = i.mdd; md_use_D = i.mdu;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    drive('0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  ins_t nop, lw8, addu8;
  logic [10:0] got, want;

  task automatic test_reset();
    drive(mk(8, 8, 1, 1, 0, 0, 2, 8, 1, 1, 1, 1));
    exp_q.push_back('0);
    #1;
    got = obs(); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("FAIL reset_held got %b want %b", got, want); end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("FAIL reset_release got %b want %b", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    ins_t s[$];
    logic [10:0] x[$];
    do_reset();
    s = '{lw8, addu8, addu8, nop};
    x = '{ex(0,0,0,0,0,0,0), ex(1,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,2,0,0,0)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL load_use step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_fwd();
    ins_t s[$];
    logic [10:0] x[$];
    ins_t ori9, beq9;
    do_reset();
    ori9 = mk(0, 0, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0);
    beq9 = mk(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    s = '{ori9, beq9, beq9, nop};
    x = '{ex(0,0,0,0,0,0,0), ex(1,0,0,0,0,0,0), ex(0,2,0,0,0,0,0), ex(0,0,0,2,0,0,0)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL branch_fwd step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_fwd_e();
    ins_t s[$];
    logic [10:0] x[$];
    do_reset();
    s = '{mk(0, 0, 1, 1, 1, 1, 1, 10, 1, 0, 0, 0), mk(0, 10, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0), nop, nop};
    x = '{ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,0,1,0,0), ex(0,0,0,0,0,1,0)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL store_fwd_e step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_fwd_m();
    ins_t s[$];
    logic [10:0] x[$];
    do_reset();
    s = '{mk(0, 0, 1, 0, 1, 0, 2, 11, 1, 0, 0, 0), mk(0, 11, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0), nop, nop};
    x = '{ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,1,0)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL store_fwd_m step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_busy();
    ins_t s[$];
    logic [10:0] x[$];
    ins_t mflo;
    do_reset();
    mflo = mk(0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1);
    s.push_back(mk(4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1)); x.push_back('0);
    s.push_back(mflo); x.push_back(ex(1,0,0,0,0,0,0));
    for (int k = 0; k < 10; k++) begin s.push_back(mflo); x.push_back(ex(1,0,0,0,0,0,1)); end
    s.push_back(mflo); x.push_back('0);
    s.push_back(mk(4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 0, 1)); x.push_back('0);
    s.push_back(mflo); x.push_back(ex(1,0,0,0,0,0,0));
    for (int k = 0; k < 5; k++) begin s.push_back(mflo); x.push_back(ex(1,0,0,0,0,0,1)); end
    s.push_back(mflo); x.push_back('0);
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL md_busy step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg_zero();
    ins_t s[$];
    logic [10:0] x[$];
    do_reset();
    s = '{mk(0, 0, 1, 1, 1, 1, 2, 0, 1, 0, 0, 0), mk(0, 0, 1, 1, 0, 0, 0, 3, 1, 0, 0, 0), nop, nop};
    x = '{ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL reg_zero step %0d got %b want %b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    ins_t s[$];
    logic [10:0] x[$];
    do_reset();
    s = '{mk(4, 5, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1), lw8, addu8};
    x = '{ex(0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0), ex(1,0,0,0,0,0,1)};
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); tests++;
      if (got !== want) begin fails++; $display("FAIL reset_mid step %0d got %b want %b", i, got, want); end
      if (i != s.size() - 1) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0;
    exp_q.push_back('0);
    #1;
    got = obs(); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("FAIL reset_async got %b want %b", got, want); end
    #1 reset = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); tests++;
    if (got !== want) begin fails++; $display("FAIL reset_after got %b want %b", got, want); end
    @(posedge clk); #1;
  endtask

  initial begin
    nop = '0;
    lw8 = mk(0, 0, 0, 0, 0, 0, 2, 8, 1, 0, 0, 0);
    addu8 = mk(8, 0, 1, 1, 1, 1, 1, 12, 1, 0, 0, 0);
    reset = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_fwd();
    test_store_fwd_e();
    test_store_fwd_m();
    test_md_busy();
    test_reg_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
